ext_mem_slave_2ch: RTL and testbench
====================================

# ext_mem_slave_2ch

Synthesizable two-channel external byte memory that answers the accelerator's master memory bus (`Mout_*`) with read data and per-channel data-ready strobes (`M_Rdata_ram`, `M_DataRdy`). Read and write latencies are configurable, and writes are masked by access size. The block sits directly downstream of the generated `main` top and replaces the behavioural off-chip memory model in FPGA-in-the-loop runs. A preload port initializes contents before `start_port` is raised.

## Interface
- `BASE_ADDR`, default 0: first bus address mapped to the memory window.
- `MEM_SIZE`, default 32: number of bytes in the window (1..128).
- `READ_DELAY`, default 2: cycles from `oe` asserted to `DataRdy` (≥2).
- `WRITE_DELAY`, default 1: cycles from `we` asserted to `DataRdy` (≥1).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `Mout_oe_ram` in 2: per-channel read enable.
- `Mout_we_ram` in 2: per-channel write enable.
- `Mout_addr_ram` in 14: channel c address is bits [7c+6:7c].
- `Mout_Wdata_ram` in 16: channel c write data is bits [8c+7:8c].
- `Mout_data_ram_size` in 8: channel c size in bits is [4c+3:4c].
- `load_en` in 1: preload write strobe.
- `load_addr` in 7: preload index, relative to `BASE_ADDR`.
- `load_data` in 8: preload byte.
- `M_Rdata_ram` out 16: per-channel read data.
- `M_DataRdy` out 2: per-channel access complete.
- `err_oe_we` out 1: sticky protocol-error flag.

## Operation
- Hit: channel c hits when `BASE_ADDR ≤ addr_c < BASE_ADDR+MEM_SIZE`. Its index is `addr_c − BASE_ADDR`. A miss never writes, reads 0, and never raises `DataRdy`.
- Mask: for size field s, mask = (1<<s)−1 when s<8, else 0xFF. s=0 gives mask 0, so the write leaves the byte unchanged.
- Write: on each rising edge with `we_c`=1, `oe_c`=0 and a hit, `mem[idx] <= (wdata & mask) | (mem[idx] & ~mask)`.
- Write ordering in one edge: channel 0 write, then channel 1 write, then preload. The last writer wins on the same index. Preload ignores `load_addr ≥ MEM_SIZE`.
- Read pipeline: per channel, READ_DELAY−1 register stages.
  - Stage input is `mem[idx]` on a hit, else 0.
  - `M_Rdata_ram` byte c is the last stage.
  - A read and a write to the same index on the same edge returns the old byte.
- Latency counter, per channel (`cnt_c`, updated on the rising edge):
  - oe & hit & !we: `cnt_c <= (cnt_c < READ_DELAY−1) ? cnt_c+1 : 0`.
  - we & hit & !oe: `cnt_c <= (cnt_c < WRITE_DELAY−1) ? cnt_c+1 : 0`.
  - Otherwise: 0.
- `M_DataRdy[c]` (combinational) = hit & !(oe&we) & ((oe & cnt_c==READ_DELAY−1) | (we & cnt_c==WRITE_DELAY−1)).
  - A master holding `oe` through `DataRdy` and beyond restarts the count, so a new read completes every READ_DELAY cycles.
- Error: `oe_c` & `we_c` both 1 on any channel at a rising edge sets `err_oe_we`.
  - That channel does not write and its `cnt_c` returns to 0.
  - The flag is cleared only by reset.
- Reset (asynchronous, `reset`=0):
  - `cnt_c`, read pipeline stages and `err_oe_we` clear immediately.
  - `M_Rdata_ram`=0; `M_DataRdy` is 0 for reads. With WRITE_DELAY=1, `M_DataRdy` still follows a write request because it is combinational.
  - Memory contents are preserved across reset.
  - While reset is low, bus writes and preload writes are blocked.

## Timing
- Read, READ_DELAY=2: `oe` asserted before edge E0.
  - At E0, `cnt`=0→1 and the pipeline captures the byte.
  - In cycle E0→E1, `DataRdy`=1 and `Rdata` is valid.
  - At E1, `cnt` wraps to 0.
- Write, WRITE_DELAY=1: `DataRdy`=1 in the same cycle `we` is high. Memory updates at the next edge.
- Write, WRITE_DELAY=N: `DataRdy` is high in cycle N−1 after `we` first asserts. Memory is written on every edge while `we` is held, which is idempotent.
- Preload: one byte per cycle, no handshake.
- The two channels are fully independent. Only shared-index ordering couples them.

## Test plan
- Parameters for all scenarios: BASE_ADDR=0x10, MEM_SIZE=32, READ_DELAY=2, WRITE_DELAY=1.
- Preload index 3=0xA5; ch0 `oe` at addr 0x13, size 8, held 1 cycle past `DataRdy` → `M_DataRdy[0]`=1 exactly one cycle after `oe`, `M_Rdata_ram[7:0]`=0xA5; `M_DataRdy[1]`=0 and `M_Rdata_ram[15:8]`=0 throughout.
- Preload index 5=0xFF; ch1 `we` at addr 0x15, data 0x00, size 4 → `M_DataRdy[1]`=1 in the `we` cycle; a later ch1 read of 0x15 returns 0xF0.
- ch0 `oe` at addr 0x30 (miss) and ch0 `we` at 0x0F (miss) → `DataRdy`=0 and `Rdata`=0 for 5 cycles; all 32 bytes unchanged.
- ch0 `oe`=`we`=1 at addr 0x12 for one cycle → `err_oe_we`=1 from the next edge and held; index 2 unchanged; `DataRdy[0]`=0. Only `reset`=0 clears the flag.
- Same edge: ch0 writes 0x11, ch1 writes 0x22 and preload writes 0x33, all to index 7 → a later read returns 0x33. Repeat without preload → 0x22.
- `reset` driven low while ch0 read has `cnt`=1 → `M_DataRdy`=0 and `M_Rdata_ram`=0 immediately. After `reset` returns high, a new read of index 3 still returns 0xA5 (contents preserved).

Source files
------------

// File: rtl/ext_mem_slave_2ch.sv
// rtl/ext_mem_slave_2ch.sv - two-channel external byte memory with size-masked writes and fixed read/write latencies
module ext_mem_slave_2ch #(
    parameter int BASE_ADDR   = 0,
    parameter int MEM_SIZE    = 32,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Mout_oe_ram,
    input  logic [1:0]  Mout_we_ram,
    input  logic [13:0] Mout_addr_ram,
    input  logic [15:0] Mout_Wdata_ram,
    input  logic [7:0]  Mout_data_ram_size,
    input  logic        load_en,
    input  logic [6:0]  load_addr,
    input  logic [7:0]  load_data,
    output logic [15:0] M_Rdata_ram,
    output logic [1:0]  M_DataRdy,
    output logic        err_oe_we
);
    localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CW        = ($clog2(MAX_DELAY) < 1) ? 1 : $clog2(MAX_DELAY);
    localparam int IW        = ($clog2(MEM_SIZE) < 1) ? 1 : $clog2(MEM_SIZE);
    localparam int STAGES    = READ_DELAY - 1;
    localparam logic [CW-1:0] RD_LAST = CW'(READ_DELAY - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WRITE_DELAY - 1);

    logic [7:0]             mem [MEM_SIZE];
    logic [1:0]             hit;
    logic [1:0][IW-1:0]     idx;
    logic [1:0][7:0]        mask;
    logic [1:0][7:0]        rd_byte;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [6:0]    addr;
        logic [3:0]    size;
        logic          oe;
        logic          we;
        logic [CW-1:0] cnt;
        logic [7:0]    pipe [STAGES];

        assign addr    = Mout_addr_ram[7*c +: 7];
        assign size    = Mout_data_ram_size[4*c +: 4];
        assign oe      = Mout_oe_ram[c];
        assign we      = Mout_we_ram[c];
        assign hit[c]  = (int'(addr) >= BASE_ADDR) && (int'(addr) < BASE_ADDR + MEM_SIZE);
        assign idx[c]  = IW'(int'(addr) - BASE_ADDR);
        assign mask[c] = (size < 4'd8) ? 8'((9'd1 << size) - 9'd1) : 8'hFF;
        assign rd_byte[c] = hit[c] ? mem[idx[c]] : 8'h00;

        assign M_Rdata_ram[8*c +: 8] = pipe[STAGES-1];
        assign M_DataRdy[c] = hit[c] & ~(oe & we) &
                              ((oe & (cnt == RD_LAST)) | (we & (cnt == WR_LAST)));

        // Counter restarts after each completion so a held request repeats every DELAY cycles.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (oe && hit[c] && !we) begin
                cnt <= (cnt < RD_LAST) ? cnt + 1'b1 : '0;
            end else if (we && hit[c] && !oe) begin
                cnt <= (cnt < WR_LAST) ? cnt + 1'b1 : '0;
            end else begin
                cnt <= '0;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s < STAGES; s++) pipe[s] <= 8'h00;
            end else begin
                pipe[0] <= rd_byte[c];
                for (int s = 1; s < STAGES; s++) pipe[s] <= pipe[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_oe_we <= 1'b0;
        end else if (|(Mout_oe_ram & Mout_we_ram)) begin
            err_oe_we <= 1'b1;
        end
    end

    // Contents survive reset; later assignments win on a shared index (ch0, ch1, preload).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                if (Mout_we_ram[c] && !Mout_oe_ram[c] && hit[c]) begin
                    mem[idx[c]] <= (Mout_Wdata_ram[8*c +: 8] & mask[c]) |
                                   (mem[idx[c]] & ~mask[c]);
                end
            end
            if (load_en && (int'(load_addr) < MEM_SIZE)) begin
                mem[IW'(load_addr)] <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_ext_mem_slave_2ch.sv
// tb/tb_ext_mem_slave_2ch.sv - randomized and directed self-checking bench for ext_mem_slave_2ch
module tb_ext_mem_slave_2ch;
    localparam int BASE = 16;
    localparam int SIZE = 32;
    localparam int RD   = 2;
    localparam int WD   = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  Mout_oe_ram = '0;
    logic [1:0]  Mout_we_ram = '0;
    logic [13:0] Mout_addr_ram = '0;
    logic [15:0] Mout_Wdata_ram = '0;
    logic [7:0]  Mout_data_ram_size = '0;
    logic        load_en = 1'b0;
    logic [6:0]  load_addr = '0;
    logic [7:0]  load_data = '0;
    logic [15:0] M_Rdata_ram;
    logic [1:0]  M_DataRdy;
    logic        err_oe_we;

    ext_mem_slave_2ch #(
        .BASE_ADDR(BASE), .MEM_SIZE(SIZE), .READ_DELAY(RD), .WRITE_DELAY(WD)
    ) dut (
        .clock(clock), .reset(reset),
        .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
        .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
        .Mout_data_ram_size(Mout_data_ram_size),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy), .err_oe_we(err_oe_we)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mem_m [SIZE];
    int         rrun [2];
    int         wrun [2];
    logic [7:0] rd_m [2];
    logic       err_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ch_addr(input int c);
        return int'(Mout_addr_ram[7*c +: 7]);
    endfunction

    function automatic bit ch_hit(input int c);
        return ch_addr(c) >= BASE && ch_addr(c) < BASE + SIZE;
    endfunction

    function automatic logic [7:0] size_mask(input int s);
        return (s < 8) ? 8'((1 << s) - 1) : 8'hFF;
    endfunction

    // Latency count implied by the length of the current uninterrupted request run.
    function automatic bit exp_rdy(input int c);
        bit oe, we;
        int cnt;
        oe  = Mout_oe_ram[c];
        we  = Mout_we_ram[c];
        cnt = (rrun[c] > 0) ? rrun[c] % RD : wrun[c] % WD;
        return ch_hit(c) && !(oe && we) && ((oe && cnt == RD - 1) || (we && cnt == WD - 1));
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            rrun[c] = 0;
            wrun[c] = 0;
            rd_m[c] = 8'h00;
        end
        err_m = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] old [SIZE];
        logic [7:0] nrd [2];
        if (!reset) begin
            model_clear();
            return;
        end
        old = mem_m;
        for (int c = 0; c < 2; c++) begin
            bit oe, we, h;
            int i;
            oe = Mout_oe_ram[c];
            we = Mout_we_ram[c];
            h  = ch_hit(c);
            i  = ch_addr(c) - BASE;
            if (oe && we) err_m = 1'b1;
            rrun[c] = (oe && h && !we) ? rrun[c] + 1 : 0;
            wrun[c] = (we && h && !oe) ? wrun[c] + 1 : 0;
            nrd[c]  = h ? old[i] : 8'h00;
            if (we && !oe && h) begin
                logic [7:0] m;
                m = size_mask(int'(Mout_data_ram_size[4*c +: 4]));
                mem_m[i] = (Mout_Wdata_ram[8*c +: 8] & m) | (old[i] & ~m);
            end
        end
        if (load_en && int'(load_addr) < SIZE) mem_m[load_addr] = load_data;
        rd_m[0] = nrd[0];
        rd_m[1] = nrd[1];
    endtask

    task automatic settle();
        #1;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("rdy%0d", c), M_DataRdy[c], exp_rdy(c));
            chk($sformatf("rdata%0d", c), M_Rdata_ram[8*c +: 8], rd_m[c]);
        end
        chk("err", err_oe_we, err_m);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic set_ch(input int c, input bit oe, input bit we, input int addr,
                          input logic [7:0] wdata, input logic [3:0] size);
        Mout_oe_ram[c] = oe;
        Mout_we_ram[c] = we;
        Mout_addr_ram[7*c +: 7] = 7'(addr);
        Mout_Wdata_ram[8*c +: 8] = wdata;
        Mout_data_ram_size[4*c +: 4] = size;
    endtask

    task automatic idle();
        set_ch(0, 0, 0, 0, 8'h00, 4'd0);
        set_ch(1, 0, 0, 0, 8'h00, 4'd0);
        load_en = 1'b0;
    endtask

    task automatic preload(input int i, input logic [7:0] d);
        load_en = 1'b1;
        load_addr = 7'(i);
        load_data = d;
        cycle();
        load_en = 1'b0;
    endtask

    initial begin
        model_clear();
        @(negedge clock);
        chk("reset_err", err_oe_we, 1'b0);
        chk("reset_rdata", M_Rdata_ram, 16'h0000);
        chk("reset_rdy", M_DataRdy, 2'b00);
        reset = 1'b1;
        tick();
        for (int i = 0; i < SIZE; i++) preload(i, 8'($urandom));

        // Read of preloaded byte, oe held one cycle past DataRdy
        preload(3, 8'hA5);
        set_ch(0, 1, 0, 'h13, 8'h00, 4'd8);
        settle();
        chk("s1_rdy_first", M_DataRdy[0], 1'b0);
        tick();
        settle();
        chk("s1_rdy", M_DataRdy[0], 1'b1);
        chk("s1_data", M_Rdata_ram[7:0], 8'hA5);
        chk("s1_ch1", {M_DataRdy[1], M_Rdata_ram[15:8]}, 9'h000);
        tick();
        settle();
        chk("s1_rdy_after", M_DataRdy[0], 1'b0);
        tick();
        idle();
        cycle();

        // Size-4 masked write
        preload(5, 8'hFF);
        set_ch(1, 0, 1, 'h15, 8'h00, 4'd4);
        settle();
        chk("s2_wrdy", M_DataRdy[1], 1'b1);
        tick();
        set_ch(1, 1, 0, 'h15, 8'h00, 4'd8);
        cycle();
        settle();
        chk("s2_data", M_Rdata_ram[15:8], 8'hF0);
        tick();
        idle();
        cycle();

        // Misses
        set_ch(0, 1, 0, 'h30, 8'h00, 4'd8);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("s3_rd_miss", {M_DataRdy[0], M_Rdata_ram[7:0]}, 9'h000);
            tick();
        end
        set_ch(0, 0, 1, 'h0F, 8'h5A, 4'd8);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("s3_wr_miss", {M_DataRdy[0], M_Rdata_ram[7:0]}, 9'h000);
            tick();
        end

        // Protocol error on ch0
        set_ch(0, 1, 1, 'h12, 8'h77, 4'd8);
        settle();
        chk("s4_rdy", M_DataRdy[0], 1'b0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("s4_err", err_oe_we, 1'b1);
            tick();
        end

        // Same-index ordering
        set_ch(0, 0, 1, 'h17, 8'h11, 4'd8);
        set_ch(1, 0, 1, 'h17, 8'h22, 4'd8);
        load_en = 1'b1; load_addr = 7'd7; load_data = 8'h33;
        cycle();
        idle();
        set_ch(0, 1, 0, 'h17, 8'h00, 4'd8);
        cycle();
        settle();
        chk("s5_preload_wins", M_Rdata_ram[7:0], 8'h33);
        tick();
        set_ch(0, 0, 1, 'h17, 8'h11, 4'd8);
        set_ch(1, 0, 1, 'h17, 8'h22, 4'd8);
        cycle();
        idle();
        set_ch(0, 1, 0, 'h17, 8'h00, 4'd8);
        cycle();
        settle();
        chk("s5_ch1_wins", M_Rdata_ram[7:0], 8'h22);
        tick();
        idle();

        // Asynchronous reset in the middle of a read
        set_ch(0, 1, 0, 'h13, 8'h00, 4'd8);
        cycle();
        settle();
        reset = 1'b0;
        #1;
        model_clear();
        chk("s6_rdy", M_DataRdy[0], 1'b0);
        chk("s6_rdata", M_Rdata_ram, 16'h0000);
        chk("s6_err", err_oe_we, 1'b0);
        idle();
        tick();
        cycle();
        reset = 1'b1;
        set_ch(0, 1, 0, 'h13, 8'h00, 4'd8);
        cycle();
        settle();
        chk("s6_preserved", M_Rdata_ram[7:0], 8'hA5);
        tick();
        idle();
        cycle();

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 1) == 0) begin
                    int r;
                    r = $urandom_range(0, 19);
                    set_ch(c, (r >= 6 && r <= 12) || r == 19, (r >= 13), 
                           $urandom_range('h0C, 'h34), 8'($urandom), 4'($urandom));
                end
            end
            load_en = ($urandom_range(0, 3) == 0);
            load_addr = 7'($urandom_range(0, 40));
            load_data = 8'($urandom);
            cycle();
        end

        // Sweep every byte on both channels
        idle();
        for (int i = 0; i < SIZE; i++) begin
            set_ch(0, 1, 0, BASE + i, 8'h00, 4'd8);
            set_ch(1, 1, 0, BASE + SIZE - 1 - i, 8'h00, 4'd8);
            cycle();
        end
        idle();
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
